// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word over req/ack, presents it to the decoder, advances PC on retire.
// Latency: ack at edge N -> instr_valid after edge N; retire at edge M -> imem_req with new pc after edge M.
// Backpressure: imem_addr held until imem_ack; instruction held until instr_ready; acks outside FETCH are dropped.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  op_code,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        instr_ready,
   input  logic        jump,
   input  logic        branch,
   input  logic        alu_zero,
   output logic        pc_src,
   output logic [31:0] retire_cnt
);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   // Low two bits of the reset PC are dropped so every fetch is word aligned.
   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   logic [31:0] pc_plus4_w;
   logic [31:0] branch_off;
   logic [31:0] jump_tgt;
   logic [31:0] next_pc;
   logic        retire;

   // Next-PC selection: jump beats taken branch beats sequential.
   always_comb begin
      pc_plus4_w = pc_q + 32'd4;
      branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      jump_tgt   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
      pc_src     = branch & alu_zero;
      next_pc    = pc_plus4_w;
      if (jump) begin
         next_pc = jump_tgt;
      end else if (pc_src) begin
         next_pc = pc_plus4_w + branch_off;
      end
   end

   // Fetch FSM: next state, register updates and memory-side outputs.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      retire_cnt_d  = retire_cnt_q;
      imem_req      = 1'b0;
      retire        = 1'b0;
      case (state_q)
         ST_START: begin
            // Any ack here belongs to a request cut off by reset; drop it.
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            retire = instr_valid_q & instr_ready;
            if (retire) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               retire_cnt_d  = retire_cnt_q + 32'd1;
               state_d       = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_START;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_START;
         pc_q          <= PC_INIT;
         instr_q       <= 32'd0;
         instr_valid_q <= 1'b0;
         retire_cnt_q  <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         retire_cnt_q  <= retire_cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign op_code     = instr_q[31:26];
   assign funct       = instr_q[5:0];
   assign pc          = pc_q;
   assign pc_plus4    = pc_plus4_w;
   assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes expected fetches into queues,
// a negedge monitor pops and compares on every accepted fetch and every new instruction.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  op_code;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_ready;
   logic        jump;
   logic        branch;
   logic        alu_zero;
   logic        pc_src;
   logic [31:0] retire_cnt;

   int tests = 0;
   int fails = 0;

   logic [31:0] addr_q[$];
   logic [31:0] word_q[$];
   logic [31:0] ipc_q[$];
   logic        vprev = 1'b0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .op_code(op_code), .funct(funct),
      .pc(pc), .pc_plus4(pc_plus4), .instr_ready(instr_ready),
      .jump(jump), .branch(branch), .alu_zero(alu_zero),
      .pc_src(pc_src), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted fetch and every newly valid instruction is checked against the queues.
   always @(negedge clk) begin
      if (!rst_n) begin
         vprev = 1'b0;
      end else begin
         if (imem_req && imem_ack) begin
            if (addr_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
            else check("fetch_addr", imem_addr, addr_q.pop_front());
         end
         if (instr_valid && !vprev) begin
            if (word_q.size() == 0) begin
               check("unexpected_instr", instr, 32'hFFFF_FFFF);
            end else begin
               logic [31:0] w, p;
               w = word_q.pop_front();
               p = ipc_q.pop_front();
               check("instr", instr, w);
               check("op_code", {26'd0, op_code}, {26'd0, w[31:26]});
               check("funct", {26'd0, funct}, {26'd0, w[5:0]});
               check("pc", pc, p);
               check("pc_plus4", pc_plus4, p + 32'd4);
            end
         end
         vprev = instr_valid;
      end
   end

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_timeout", {31'd0, imem_req}, 32'd1);
   endtask

   // Fetch one word: ack after 'delay' cycles; while waiting, drive stray retire inputs that must be ignored.
   task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay,
                           input logic stray);
      addr_q.push_back(exp_addr);
      word_q.push_back(word);
      ipc_q.push_back(exp_addr);
      wait_req();
      for (int i = 0; i < delay; i++) begin
         instr_ready = stray;
         jump        = stray;
         @(negedge clk);
         check("addr_stable", imem_addr, exp_addr);
         check("req_stable", {31'd0, imem_req}, 32'd1);
         @(posedge clk); #1;
      end
      instr_ready = 1'b0;
      jump        = 1'b0;
      imem_ack    = 1'b1;
      imem_rdata  = word;
      @(posedge clk); #1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
   endtask

   task automatic do_retire(input logic j, input logic b, input logic z, input logic [31:0] exp_cnt);
      check("valid_before_retire", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
      jump        = j;
      branch      = b;
      alu_zero    = z;
      @(negedge clk);
      check("pc_src", {31'd0, pc_src}, {31'd0, b & z});
      @(posedge clk); #1;
      instr_ready = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      alu_zero    = 1'b0;
      @(negedge clk);
      check("retire_cnt", retire_cnt, exp_cnt);
      check("valid_after_retire", {31'd0, instr_valid}, 32'd0);
      check("req_after_retire", {31'd0, imem_req}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      instr_ready = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      alu_zero    = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_cnt", retire_cnt, 32'd0);
      check("rst_pc", pc, 32'h0000_0100);
      check("rst_instr", instr, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("start_no_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk); #1;

      // T1: sequential fetch, ack one cycle after request
      do_fetch(32'h0000_0100, 32'h0000_0020, 1, 1'b0);
      do_retire(1'b0, 1'b0, 1'b0, 32'd1);
      // jump from 0x104 to 0x200
      do_fetch(32'h0000_0104, 32'h0800_0080, 0, 1'b0);
      do_retire(1'b1, 1'b0, 1'b0, 32'd2);

      // T2: beq imm=-1 taken loops to itself, not taken falls through
      do_fetch(32'h0000_0200, 32'h1000_FFFF, 0, 1'b0);
      do_retire(1'b0, 1'b1, 1'b1, 32'd3);
      do_fetch(32'h0000_0200, 32'h1000_FFFF, 0, 1'b0);
      do_retire(1'b0, 1'b1, 1'b0, 32'd4);

      // T4: ack after 5 cycles with stray instr_ready in FETCH, then a 3-cycle stall with a spurious ack
      do_fetch(32'h0000_0204, 32'h2108_0001, 5, 1'b1);
      for (int i = 0; i < 3; i++) begin
         imem_ack   = (i == 1);
         imem_rdata = 32'hFFFF_0000;
         @(negedge clk);
         check("hold_instr", instr, 32'h2108_0001);
         check("hold_valid", {31'd0, instr_valid}, 32'd1);
         check("hold_req", {31'd0, imem_req}, 32'd0);
         check("hold_pc", pc, 32'h0000_0204);
         check("hold_cnt", retire_cnt, 32'd4);
         @(posedge clk); #1;
      end
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      // taken branch with +1 offset: 0x208 + 4
      do_retire(1'b0, 1'b1, 1'b1, 32'd5);

      // T3: place pc at 0x4000_0000 while fetching 0x20C, then jump wins over taken branch
      wait_req();
      check("seq_addr_20c", imem_addr, 32'h0000_020C);
      force dut.pc_d = 32'h4000_0000;
      @(posedge clk); #1;
      release dut.pc_d;
      do_fetch(32'h4000_0000, 32'h0800_0010, 0, 1'b0);
      do_retire(1'b1, 1'b1, 1'b1, 32'd6);

      // T5: pc wrap and retire_cnt wrap
      wait_req();
      check("jump_addr", imem_addr, 32'h4000_0040);
      force dut.pc_d = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      release dut.pc_d;
      do_fetch(32'hFFFF_FFFC, 32'h0000_0020, 2, 1'b0);
      force dut.retire_cnt_d = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut.retire_cnt_d;
      @(negedge clk);
      check("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      do_retire(1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      check("pc_wrap_addr", imem_addr, 32'h0000_0000);

      // T6: reset while FETCH is pending, ack arriving in the first cycle after release
      @(posedge clk); #2;
      rst_n      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      #1;
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      check("midrst_cnt", retire_cnt, 32'd0);
      check("midrst_pc", pc, 32'h0000_0100);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("start_ack_req", {31'd0, imem_req}, 32'd0);
      check("start_ack_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("late_ack_dropped", {31'd0, instr_valid}, 32'd0);
      check("first_req", {31'd0, imem_req}, 32'd1);
      check("first_req_addr", imem_addr, 32'h0000_0100);
      @(posedge clk); #1;
      do_fetch(32'h0000_0100, 32'h0000_0020, 0, 1'b0);
      do_retire(1'b0, 1'b0, 1'b0, 32'd1);

      check("addr_q_drained", addr_q.size(), 32'd0);
      check("word_q_drained", word_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
